fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output reorder stage that sits directly downstream of the final saturator stage of the 4-lane parallel FFT. It takes each N-point frame as 4 complex samples per clock, in bit-reversed bin order, and re-emits it in natural bin order on the same 4-lane format. Storage is a ping-pong pair of frame buffers, so back-to-back frames stream without gaps. All buffering is flop-based; no block RAM.

## Interface
- NBITS, 21, bits per real/imag component; each lane word is {re, im} = 2*NBITS bits, re in the upper half.
- N, 128, FFT length; power of 2, N >= 8; frame length is N/4 clock cycles.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down  in  2*NBITS each  lanes 0..3 of the input sample group.
- in_enable  in  1  per-cycle valid; lanes are captured only when high.
- fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down  out  2*NBITS each  lanes 0..3 of the output group, registered.
- o_enable  out  1  high while the output lanes carry valid reordered data, registered.
- o_frame_start  out  1  high with the first output group of each frame, registered.

## Operation
- Input indexing:
  - Write counter wc counts 0..N/4-1 and advances only on cycles with in_enable high.
  - Lane l (0=In0_up, 1=In0_down, 2=In1_up, 3=In1_down) carries position p = 4*wc + l.
  - The sample's bin is bitrev(p) over log2(N) bits. It is stored at that bin address in write bank wb.
  - Example, N=128, wc=0: lanes carry bins 0, 64, 32, 96.
- Frame complete: a valid cycle with wc = N/4-1. On that clock:
  - wc wraps to 0 and wb toggles.
  - The reader loads rb = old wb, rc = 0, and state = READ.
- Reader FSM:
  - IDLE: o_enable = 0 and output lanes = 0.
  - READ: each cycle, read bins 4*rc..4*rc+3 from bank rb into lanes 0..3 (registered), then increment rc.
  - After rc = N/4-1: go to IDLE, unless a frame completes on that same clock. In that case restart READ with rc = 0 on the new bank. This restart has priority and leaves no gap.
- No overflow is possible. A frame needs at least N/4 valid cycles, so readout of bank X always finishes no later than the next completion, which reuses bank X for writing.
- Gaps in in_enable stall wc only. The reader is unaffected.
- No arithmetic: data passes bit-exact, with no rounding or saturation.
- Reset, including mid-frame or mid-readout:
  - wc = 0, wb = 0, reader IDLE.
  - Partial frames and pending readouts are discarded.
  - Buffer contents need not be cleared.
  - All outputs are 0 in the cycle after the one where rst is sampled high.
- While rst is high, in_enable is ignored.

## Timing
- Cycle n is the period after clock edge n. Inputs presented in cycle n are sampled at edge n+1.
- Frame latency: if the last input of a frame is presented in cycle L, o_enable is high in cycles L+2 .. L+1+N/4.
- o_frame_start is high in cycle L+2 only.
- Continuous input gives continuous o_enable after the initial latency.
- Reset values: all four output lanes = 0, o_enable = 0, o_frame_start = 0.
- Output lanes are 0 in every cycle where o_enable = 0.

## Test plan
- **Single frame (N=128).** In cycles 0..31, present re = bin, im = -bin for each lane's bitrev(p) bin, with in_enable high.
  - Required: o_enable high in cycles 33..64, o_frame_start high in cycle 33 only.
  - In cycle 33+k, lanes carry re = 4k..4k+3.
- **Back-to-back frames.** Frame A in cycles 0..31, frame B in cycles 32..63, with B's tags offset by +1000.
  - Required: o_enable continuous in cycles 33..96, o_frame_start high in cycles 33 and 65.
  - Frame B's data is in natural order, and frame A's data is not corrupted.
- **Gapped input.** Run the single-frame stimulus but hold in_enable low in cycles 10..14, so the frame's last input lands in cycle 36.
  - Required: o_enable high in cycles 38..69 with correct order; nothing is captured during the gap.
- **Reset mid-frame.** Hold rst high in cycle 20, then present a full new frame in cycles 21..52.
  - Required: no output from the partial frame.
  - o_enable high in cycles 54..85 with the new frame's data in order.
- **Reset mid-readout.** Present a frame in cycles 0..31, then hold rst high in cycle 40.
  - Required: o_enable = 0 and lanes = 0 from cycle 41 onward; no further valid output.
- **Bit-exactness.** Use a frame of extreme values (0x0FFFFF, 0x100000, 0x1FFFFF per component).
  - Required: every value reappears unmodified at its natural-order position.

Source files
------------

// File: rtl/fft_out_reorder_if.sv
// Four-lane complex sample bus between the FFT back end and the output
// reorder stage. Carries both the input group (bit-reversed order) and the
// registered output group (natural order) of the reorder block.
//   fftIn0_up .. fftIn1_down   : input lanes 0..3, {re, im}, re in upper half
//   in_enable                  : input group valid
//   fftOut0_up .. fftOut1_down : output lanes 0..3, {re, im}
//   o_enable                   : output group valid
//   o_frame_start              : first output group of a frame
// slave  : the reorder block (consumes inputs, drives outputs)
// master : the producer/observer side
interface fft_out_reorder_if #(
  parameter int NBITS = 21
);
  logic [2*NBITS-1:0] fftIn0_up;
  logic [2*NBITS-1:0] fftIn0_down;
  logic [2*NBITS-1:0] fftIn1_up;
  logic [2*NBITS-1:0] fftIn1_down;
  logic               in_enable;
  logic [2*NBITS-1:0] fftOut0_up;
  logic [2*NBITS-1:0] fftOut0_down;
  logic [2*NBITS-1:0] fftOut1_up;
  logic [2*NBITS-1:0] fftOut1_down;
  logic               o_enable;
  logic               o_frame_start;

  modport slave (
    input  fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
    output fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down,
           o_enable, o_frame_start
  );

  modport master (
    output fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down, in_enable,
    input  fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down,
           o_enable, o_frame_start
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Output reorder stage of the 4-lane parallel FFT. Frames arrive as N/4
// groups of 4 complex samples in bit-reversed bin order and leave in natural
// bin order, same 4-lane format. Two flop-based frame banks are used
// ping-pong so back-to-back frames stream with no gap.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : fft_out_reorder_if.slave (input lanes + in_enable, registered
//         output lanes + o_enable + o_frame_start)
//
// Reader FSM
//   state | meaning
//   IDLE  | no readout pending, outputs held at 0
//   READ  | emitting bins 4*rc..4*rc+3 of bank rb each cycle
module fft_out_reorder #(
  parameter int NBITS = 21,
  parameter int N     = 128
) (
  input  logic             clk,
  input  logic             rst,
  fft_out_reorder_if.slave bus
);
  localparam int LOGN = $clog2(N);
  localparam int CW   = LOGN - 2;
  localparam int W    = 2 * NBITS;
  localparam logic [CW-1:0] LAST = CW'(N / 4 - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  wc;
  logic           wb;
  logic [CW-1:0]  rc, rc_nxt;
  logic           rb, rb_nxt;
  logic           rd_fire;
  logic           frame_done;

  logic [W-1:0]   mem [2][N];
  logic [W-1:0]   lane_in [4];
  logic [W-1:0]   lane_out [4];
  logic           out_en;
  logic           out_fs;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] p);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = p[LOGN-1-i];
    return r;
  endfunction

  assign lane_in[0] = bus.fftIn0_up;
  assign lane_in[1] = bus.fftIn0_down;
  assign lane_in[2] = bus.fftIn1_up;
  assign lane_in[3] = bus.fftIn1_down;

  assign frame_done = bus.in_enable && (wc == LAST);

  // Write side: wc wraps naturally because N/4 is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wc <= '0;
      wb <= 1'b0;
    end else if (bus.in_enable) begin
      wc <= wc + 1'b1;
      if (wc == LAST) wb <= ~wb;
    end
  end

  // Frame banks carry no reset; stale contents are never read before rewrite.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_enable) begin
      for (int l = 0; l < 4; l++) begin
        mem[wb][bitrev({wc, 2'(l)})] <= lane_in[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rc    <= '0;
      rb    <= 1'b0;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
      rb    <= rb_nxt;
    end
  end

  // A completing frame overrides the end-of-readout return to IDLE so the
  // next frame starts on the very next cycle.
  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    rb_nxt    = rb;
    rd_fire   = 1'b0;
    if (state == READ) begin
      rd_fire = 1'b1;
      rc_nxt  = rc + 1'b1;
      if (rc == LAST) state_nxt = IDLE;
    end
    if (frame_done) begin
      state_nxt = READ;
      rc_nxt    = '0;
      rb_nxt    = wb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !rd_fire) begin
      out_en <= 1'b0;
      out_fs <= 1'b0;
      for (int l = 0; l < 4; l++) lane_out[l] <= '0;
    end else begin
      out_en <= 1'b1;
      out_fs <= (rc == '0);
      for (int l = 0; l < 4; l++) lane_out[l] <= mem[rb][{rc, 2'(l)}];
    end
  end

  assign bus.fftOut0_up    = lane_out[0];
  assign bus.fftOut0_down  = lane_out[1];
  assign bus.fftOut1_up    = lane_out[2];
  assign bus.fftOut1_down  = lane_out[3];
  assign bus.o_enable      = out_en;
  assign bus.o_frame_start = out_fs;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder (NBITS=21, N=128). Each tick presents
// one input cycle and checks the outputs of that cycle at the falling edge
// against the cycle timing and natural-order contents the block must produce.
module tb_fft_out_reorder;
  localparam int NB   = 21;
  localparam int N    = 128;
  localparam int LOGN = 7;
  localparam int W    = 2 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft_out_reorder_if #(.NBITS(NB)) bus ();

  fft_out_reorder #(.NBITS(NB), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic int brev(input int p);
    int r = 0;
    int q = p;
    for (int i = 0; i < LOGN; i++) begin
      r = (r << 1) | (q & 1);
      q = q >> 1;
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] ext(input int s);
    case (s)
      0:       return 21'h0FFFFF;
      1:       return 21'h100000;
      default: return 21'h1FFFFF;
    endcase
  endfunction

  // Sample for a given bin: mode 0 -> re = bin+tag, im = -(bin+tag);
  // mode 1 -> extreme component values selected by bin.
  function automatic logic [W-1:0] dw(input int mode, input int bin, input int tag);
    logic [NB-1:0] re, im;
    if (mode == 0) begin
      re = NB'(bin + tag);
      im = NB'(-(bin + tag));
    end else begin
      re = ext(bin % 3);
      im = ext((bin + 1) % 3);
    end
    return {re, im};
  endfunction

  task automatic chk(input string tag, input int c, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, got, exp);
      end
  endtask

  task automatic tick(input int c, input logic r, input logic en, input int grp,
                      input int mode, input int tag, input logic xe, input logic xf,
                      input int xk, input int xmode, input int xtag);
    logic [W-1:0] got [4];
    logic [W-1:0] exp;
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_enable = en;
    if (en) begin
      bus.fftIn0_up   = dw(mode, brev(4 * grp + 0), tag);
      bus.fftIn0_down = dw(mode, brev(4 * grp + 1), tag);
      bus.fftIn1_up   = dw(mode, brev(4 * grp + 2), tag);
      bus.fftIn1_down = dw(mode, brev(4 * grp + 3), tag);
    end else begin
      bus.fftIn0_up   = dw(0, 777, 0);
      bus.fftIn0_down = dw(0, 778, 0);
      bus.fftIn1_up   = dw(0, 779, 0);
      bus.fftIn1_down = dw(0, 780, 0);
    end
    @(negedge clk);
    got[0] = bus.fftOut0_up;
    got[1] = bus.fftOut0_down;
    got[2] = bus.fftOut1_up;
    got[3] = bus.fftOut1_down;
    chk("o_enable", c, W'(bus.o_enable), W'(xe));
    chk("o_frame_start", c, W'(bus.o_frame_start), W'(xf));
    for (int l = 0; l < 4; l++) begin
      exp = xe ? dw(xmode, 4 * xk + l, xtag) : '0;
      chk($sformatf("lane%0d", l), c, got[l], exp);
    end
  endtask

  task automatic do_reset();
    tick(-1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    bus.in_enable   = 1'b0;
    bus.fftIn0_up   = '0;
    bus.fftIn0_down = '0;
    bus.fftIn1_up   = '0;
    bus.fftIn1_down = '0;
    repeat (2) @(posedge clk);

    // Single frame
    do_reset();
    for (int c = 0; c <= 70; c++)
      tick(c, 1'b0, c < 32, c, 0, 0, (c >= 33 && c <= 64), c == 33, c - 33, 0, 0);

    // Back-to-back frames, B tagged +1000
    do_reset();
    for (int c = 0; c <= 100; c++)
      tick(c, 1'b0, c < 64, c % 32, 0, (c < 32) ? 0 : 1000,
           (c >= 33 && c <= 96), (c == 33 || c == 65), (c - 33) % 32,
           0, (c < 65) ? 0 : 1000);

    // Gapped input: in_enable low in cycles 10..14
    do_reset();
    for (int c = 0; c <= 72; c++)
      tick(c, 1'b0, (c < 37) && !(c >= 10 && c <= 14), (c < 10) ? c : c - 5, 0, 0,
           (c >= 38 && c <= 69), c == 38, c - 38, 0, 0);

    // Reset mid-frame (in_enable held high during the reset cycle)
    do_reset();
    for (int c = 0; c <= 88; c++)
      tick(c, c == 20, c <= 52, (c <= 20) ? c : c - 21, 0, (c <= 20) ? 500 : 2000,
           (c >= 54 && c <= 85), c == 54, c - 54, 0, 2000);

    // Reset mid-readout
    do_reset();
    for (int c = 0; c <= 75; c++)
      tick(c, c == 40, c < 32, c, 0, 300, (c >= 33 && c <= 40), c == 33, c - 33, 0, 300);

    // Bit-exactness with extreme component values
    do_reset();
    for (int c = 0; c <= 70; c++)
      tick(c, 1'b0, c < 32, c, 1, 0, (c >= 33 && c <= 64), c == 33, c - 33, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
